// File: rtl/adex_param_streamer.sv
// Host-side nibble-serial transmitter that streams eight AdEx parameter bytes to the neuron loader.
// Optional abort input: define ADEX_STREAM_ABORT_EN.
module adex_param_streamer #(
    parameter logic [7:0] LOW_CYC    = 8'd2,
    parameter logic [7:0] HIGH_CYC   = 8'd2,
    parameter logic [7:0] HOLD_CYC   = 8'd4,
    parameter logic [3:0] FOOTER_NIB = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] param_vec,
`ifdef ADEX_STREAM_ABORT_EN
    input  logic        abort,
`endif
    output logic        load_mode,
    output logic        load_enable,
    output logic [3:0]  nibble_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYM_LOW  = 3'd1,
        SYM_HIGH = 3'd2,
        HOLD     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'd17;

    state_t      r_state;
    state_t      w_state_nx;
    logic [7:0]  r_phase;
    logic [7:0]  w_phase_nx;
    logic [4:0]  r_idx;
    logic [4:0]  w_idx_nx;
    logic [63:0] r_shadow;
    logic [63:0] w_shadow_nx;
    logic        r_load_mode;
    logic        w_load_mode_nx;
    logic        r_load_enable;
    logic        w_load_enable_nx;
    logic [3:0]  r_nibble;
    logic [3:0]  w_nibble_nx;
    logic        r_busy;
    logic        w_busy_nx;
    logic        r_done;
    logic        w_done_nx;
    logic        w_abort;

    // Symbol 0 is the header, 1..16 walk the parameters high nibble first, 17 is the footer.
    function automatic logic [3:0] sym_nibble(input logic [63:0] params, input logic [4:0] idx);
        logic [63:0] shifted;
        logic [4:0]  ofs;
        shifted = 64'd0;
        ofs     = idx - 5'd1;
        if (idx == 5'd0) begin
            sym_nibble = 4'h0;
        end else if (idx == LAST_IDX) begin
            sym_nibble = FOOTER_NIB;
        end else begin
            shifted    = params << {ofs, 2'b00};
            sym_nibble = shifted[63:60];
        end
    endfunction

`ifdef ADEX_STREAM_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Next-state and next-output logic for the symbol sequencer
    always_comb begin
        w_state_nx       = r_state;
        w_phase_nx       = r_phase;
        w_idx_nx         = r_idx;
        w_shadow_nx      = r_shadow;
        w_load_mode_nx   = r_load_mode;
        w_load_enable_nx = r_load_enable;
        w_nibble_nx      = r_nibble;
        w_busy_nx        = r_busy;
        w_done_nx        = 1'b0;
        if (w_abort && (r_state != IDLE) && (r_state != DONE)) begin
            w_state_nx       = DONE;
            w_phase_nx       = 8'd0;
            w_load_mode_nx   = 1'b0;
            w_load_enable_nx = 1'b0;
            w_nibble_nx      = 4'h0;
            w_busy_nx        = 1'b0;
            w_done_nx        = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nx       = SYM_LOW;
                        w_shadow_nx      = param_vec;
                        w_idx_nx         = 5'd0;
                        w_phase_nx       = 8'd0;
                        w_load_mode_nx   = 1'b1;
                        w_load_enable_nx = 1'b0;
                        w_nibble_nx      = 4'h0;
                        w_busy_nx        = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
                SYM_LOW: begin
                    if (r_phase == (LOW_CYC - 8'd1)) begin
                        w_state_nx       = SYM_HIGH;
                        w_phase_nx       = 8'd0;
                        w_load_enable_nx = 1'b1;
                    end else begin
                        w_phase_nx = r_phase + 8'd1;
                    end
                end
                SYM_HIGH: begin
                    if (r_phase == (HIGH_CYC - 8'd1)) begin
                        w_phase_nx       = 8'd0;
                        w_load_enable_nx = 1'b0;
                        if (r_idx == LAST_IDX) begin
                            w_state_nx  = HOLD;
                            w_nibble_nx = 4'h0;
                        end else begin
                            w_state_nx  = SYM_LOW;
                            w_idx_nx    = r_idx + 5'd1;
                            w_nibble_nx = sym_nibble(r_shadow, r_idx + 5'd1);
                        end
                    end else begin
                        w_phase_nx = r_phase + 8'd1;
                    end
                end
                HOLD: begin
                    if (r_phase == (HOLD_CYC - 8'd1)) begin
                        w_state_nx     = DONE;
                        w_phase_nx     = 8'd0;
                        w_load_mode_nx = 1'b0;
                        w_busy_nx      = 1'b0;
                        w_done_nx      = 1'b1;
                    end else begin
                        w_phase_nx = r_phase + 8'd1;
                    end
                end
                DONE: begin
                    w_state_nx     = IDLE;
                    w_load_mode_nx = 1'b0;
                    w_busy_nx      = 1'b0;
                end
                default: begin
                    w_state_nx       = IDLE;
                    w_phase_nx       = 8'd0;
                    w_idx_nx         = 5'd0;
                    w_load_mode_nx   = 1'b0;
                    w_load_enable_nx = 1'b0;
                    w_nibble_nx      = 4'h0;
                    w_busy_nx        = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, counters, parameter shadow and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_phase       <= 8'd0;
            r_idx         <= 5'd0;
            r_shadow      <= 64'd0;
            r_load_mode   <= 1'b0;
            r_load_enable <= 1'b0;
            r_nibble      <= 4'h0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_phase       <= w_phase_nx;
            r_idx         <= w_idx_nx;
            r_shadow      <= w_shadow_nx;
            r_load_mode   <= w_load_mode_nx;
            r_load_enable <= w_load_enable_nx;
            r_nibble      <= w_nibble_nx;
            r_busy        <= w_busy_nx;
            r_done        <= w_done_nx;
        end
    end

    assign load_mode   = r_load_mode;
    assign load_enable = r_load_enable;
    assign nibble_out  = r_nibble;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: doc/adex_param_streamer.md
Name: adex_param_streamer

Overview:
- Host-side transmitter for the AdEx neuron's nibble-serial parameter loader.
- Takes eight 8-bit neuron parameters and drives load_mode, load_enable strobes and 4-bit nibble data. The sequence is header strobe, 16 data nibbles (high nibble first), then footer nibble 4'hF.
- Sits on the test/host side (FPGA harness or on-chip sequencer) facing the neuron's ui_in[4:3]/uio_in[3:0] pins. Its waveform must be accepted by the neuron's loader without watchdog expiry.

Parameters:
- LOW_CYC, 2, cycles load_enable is held low at the start of each symbol (legal range 2..255).
- HIGH_CYC, 2, cycles load_enable is held high at the end of each symbol (legal range 1..255).
- HOLD_CYC, 4, cycles load_mode stays high after the footer symbol ends (legal range 1..255).
- FOOTER_NIB, 4'hF, nibble value sent in the footer symbol.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a transfer; sampled only while busy=0.
- param_vec  in  64  packed parameters, sampled on accepted start. [63:56]=DeltaT, [55:48]=TauW, [47:40]=a, [39:32]=b, [31:24]=Vreset, [23:16]=VT, [15:8]=Ibias, [7:0]=C.
- load_mode  out  1  drives neuron ui_in[4].
- load_enable  out  1  drives neuron ui_in[3] (strobe).
- nibble_out  out  4  drives neuron uio_in[3:0].
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a transfer completes.
- abort  in  1  present only with ADEX_STREAM_ABORT_EN.

Behaviour:
- All outputs are registered. Reset (async assert, sync release) forces: load_mode=0, load_enable=0, nibble_out=0, busy=0, done=0, state=IDLE, symbol counter=0, phase counter=0, shadow params=0.
- States: IDLE, SYM_LOW, SYM_HIGH, HOLD, DONE.
- IDLE: start=1 captures param_vec into shadow, sets symbol idx=0, and enters SYM_LOW. On the next cycle load_mode=1 and busy=1.
- Symbol idx runs 0..17:
  - idx 0 = header, nibble_out=0 (value ignored by the receiver).
  - idx 1..16 = data; byte k=(idx-1)>>1 taken MSB-byte first. Odd idx sends the high nibble, even idx the low nibble.
  - idx 17 = footer, nibble_out=FOOTER_NIB.
- nibble_out is stable for the whole symbol (LOW_CYC+HIGH_CYC cycles), set on entry to SYM_LOW.
- SYM_LOW: load_enable=0 for exactly LOW_CYC cycles, then SYM_HIGH.
- SYM_HIGH: load_enable=1 for exactly HIGH_CYC cycles. Then go to SYM_LOW with idx+1, or to HOLD if idx=17.
- HOLD: load_mode=1, load_enable=0, nibble_out=0 for HOLD_CYC cycles, then DONE.
- DONE (one cycle): load_mode=0, busy=0, done=1. Next cycle returns to IDLE with done=0.
- Exactly 18 rising edges of load_enable per transfer, all with load_mode=1.
- Transfer length from the start-accept edge to the done-high cycle is 18*(LOW_CYC+HIGH_CYC)+HOLD_CYC+1 cycles. With defaults this is 77.
- LOW_CYC>=2 guarantees the receiver's latch cycle and its edge detector see load_enable low between strobes.
- start while busy=1 is ignored. start in the DONE cycle is ignored. start in IDLE the cycle after DONE is accepted.
- A param_vec change mid-transfer has no effect; the shadow register is used.
- Reset mid-transfer: load_mode and load_enable drop immediately (async), so the receiver aborts via its !load_mode path.
- Counters are sized to 8 bits for the phase counter and 5 bits for idx; they never wrap within legal parameter ranges.

Optional Feature:
- ADEX_STREAM_ABORT_EN defined: abort port exists. abort=1 in any state other than IDLE/DONE goes to DONE on the next edge: load_mode=0, load_enable=0, done pulses, busy drops. abort has priority over phase advance. abort in IDLE does nothing.
- Not defined: no abort port; a transfer always runs to completion.

Test Plan:
- Defaults, param_vec=64'h02_64_02_28_3F_4E_8F_C8, single start -> exactly 18 load_enable rising edges. Nibble at the edges: 0,0,2,6,4,0,2,2,8,3,F,4,E,8,F,C,8,F. done high 77 cycles after the accept edge.
- Same stream fed into the neuron loader model -> receiver registers equal the bytes and r_ready=1 before load_mode falls. load_mode falls and the receiver returns to idle.
- start pulsed during the transfer at symbol 5, and again in the DONE cycle -> both ignored. Only one done pulse; a start the cycle after DONE launches a second full transfer.
- param_vec changed to all-ones during symbol 3 -> transmitted nibbles still match the captured value.
- reset asserted mid-transfer at symbol 9, HIGH phase -> load_mode, load_enable and busy are 0 before the next clock edge; after release the block idles until start.
- With ADEX_STREAM_ABORT_EN, abort during symbol 12 -> next cycle load_mode=0, done=1 for one cycle, no footer strobe emitted. Without the macro, the full 18-strobe sequence occurs.
